// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation from dispatch, out-of-order completion
// from the execution pipes, in-order retire with mispredict/exception flush.
module reorder_buffer #(
    parameter int NUM_ROB_ENTS = 64,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 4,
    parameter int NUM_FUS      = 4,
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 128,
    localparam int IW = $clog2(NUM_ROB_ENTS),
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DISP_WIDTH-1:0]      disp_valid,
    input  logic [DISP_WIDTH*AW-1:0]   disp_dst_areg,
    input  logic [DISP_WIDTH*PW-1:0]   disp_dst_preg,
    input  logic [DISP_WIDTH*PW-1:0]   disp_old_preg,
    input  logic [DISP_WIDTH*32-1:0]   disp_pc,
    output logic                       disp_ready,
    output logic [DISP_WIDTH*IW-1:0]   disp_rob_index,
    input  logic [NUM_FUS-1:0]         cmpl_valid,
    input  logic [NUM_FUS*IW-1:0]      cmpl_rob_index,
    input  logic [NUM_FUS-1:0]         cmpl_exception,
    input  logic [NUM_FUS-1:0]         cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]    ret_valid,
    output logic [RETIRE_WIDTH*AW-1:0] ret_dst_areg,
    output logic [RETIRE_WIDTH*PW-1:0] ret_dst_preg,
    output logic [RETIRE_WIDTH*PW-1:0] ret_old_preg,
    output logic [RETIRE_WIDTH*32-1:0] ret_pc,
    output logic                       flush,
    output logic                       flush_exception,
    output logic [31:0]                flush_pc,
    output logic [IW:0]                count,
    output logic                       empty
);

    localparam int CW = IW + 1;

    logic [IW:0]    head_r;
    logic [IW:0]    tail_r;
    logic           ent_valid_r [NUM_ROB_ENTS];
    logic           ent_done_r  [NUM_ROB_ENTS];
    logic           ent_exc_r   [NUM_ROB_ENTS];
    logic           ent_mis_r   [NUM_ROB_ENTS];
    logic [AW-1:0]  ent_areg_r  [NUM_ROB_ENTS];
    logic [PW-1:0]  ent_preg_r  [NUM_ROB_ENTS];
    logic [PW-1:0]  ent_old_r   [NUM_ROB_ENTS];
    logic [31:0]    ent_pc_r    [NUM_ROB_ENTS];

    logic [IW:0]             count_s;
    logic [IW:0]             space_s;
    logic [IW:0]             n_alloc_s;
    logic [IW:0]             n_commit_s;
    logic [IW:0]             flush_head_s;
    logic [IW-1:0]           head_idx_s;
    logic [IW-1:0]           tail_idx_s;
    logic [DISP_WIDTH-1:0]   alloc_s;
    logic                    run_s;
    logic [IW-1:0]           cmpl_off_s [NUM_FUS];
    logic [NUM_FUS-1:0]      cmpl_hit_s;
    logic [IW-1:0]           ret_idx_s [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] ret_valid_s;
    logic                    stop_s;
    logic                    flush_s;
    logic                    flush_exc_s;
    logic [31:0]             flush_pc_s;

    // Occupancy and dispatch acceptance, all from start-of-cycle pointers.
    always_comb begin
        head_idx_s = head_r[IW-1:0];
        tail_idx_s = tail_r[IW-1:0];
        count_s    = tail_r - head_r;
        space_s    = CW'(NUM_ROB_ENTS) - count_s;
        disp_ready = (space_s >= CW'(DISP_WIDTH)) && !flush_s;
        count      = count_s;
        empty      = (count_s == '0);
    end

    // Only the leading contiguous run of requests is allocated, at tail+k.
    always_comb begin
        alloc_s        = '0;
        n_alloc_s      = '0;
        run_s          = 1'b1;
        disp_rob_index = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            disp_rob_index[k*IW +: IW] = tail_idx_s + IW'(k);
            if (disp_ready && run_s && disp_valid[k]) begin
                alloc_s[k] = 1'b1;
                n_alloc_s  = n_alloc_s + CW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // A completion counts only when its index lies inside [head, tail).
    always_comb begin
        cmpl_hit_s = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            cmpl_off_s[f] = cmpl_rob_index[f*IW +: IW] - head_idx_s;
            cmpl_hit_s[f] = cmpl_valid[f] && ({1'b0, cmpl_off_s[f]} < count_s);
        end
    end

    // In-order retire scan; a flagged entry ends the scan and raises flush.
    always_comb begin
        ret_valid_s  = '0;
        n_commit_s   = '0;
        stop_s       = 1'b0;
        flush_s      = 1'b0;
        flush_exc_s  = 1'b0;
        flush_pc_s   = 32'h0000_0000;
        ret_dst_areg = '0;
        ret_dst_preg = '0;
        ret_old_preg = '0;
        ret_pc       = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_idx_s[k]               = head_idx_s + IW'(k);
            ret_dst_areg[k*AW +: AW]   = ent_areg_r[ret_idx_s[k]];
            ret_dst_preg[k*PW +: PW]   = ent_preg_r[ret_idx_s[k]];
            ret_old_preg[k*PW +: PW]   = ent_old_r[ret_idx_s[k]];
            ret_pc[k*32 +: 32]         = ent_pc_r[ret_idx_s[k]];
            if (!stop_s && ent_valid_r[ret_idx_s[k]] && ent_done_r[ret_idx_s[k]]) begin
                if (ent_exc_r[ret_idx_s[k]]) begin
                    // Excepting instruction never commits.
                    flush_s     = 1'b1;
                    flush_exc_s = 1'b1;
                    flush_pc_s  = ent_pc_r[ret_idx_s[k]];
                    stop_s      = 1'b1;
                end else begin
                    ret_valid_s[k] = 1'b1;
                    n_commit_s     = n_commit_s + CW'(1);
                    if (ent_mis_r[ret_idx_s[k]]) begin
                        flush_s    = 1'b1;
                        flush_pc_s = ent_pc_r[ret_idx_s[k]];
                        stop_s     = 1'b1;
                    end else begin
                        stop_s = 1'b0;
                    end
                end
            end else begin
                stop_s = 1'b1;
            end
        end
        flush_head_s    = head_r + n_commit_s + (flush_exc_s ? CW'(1) : CW'(0));
        ret_valid       = ret_valid_s;
        flush           = flush_s;
        flush_exception = flush_exc_s;
        flush_pc        = flush_pc_s;
    end

    // Pointer and entry state update; a flush overrides dispatch and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
            for (int i = 0; i < NUM_ROB_ENTS; i++) begin
                ent_valid_r[i] <= 1'b0;
                ent_done_r[i]  <= 1'b0;
                ent_exc_r[i]   <= 1'b0;
                ent_mis_r[i]   <= 1'b0;
                ent_areg_r[i]  <= '0;
                ent_preg_r[i]  <= '0;
                ent_old_r[i]   <= '0;
                ent_pc_r[i]    <= 32'h0000_0000;
            end
        end else if (flush_s) begin
            head_r <= flush_head_s;
            tail_r <= flush_head_s;
            for (int i = 0; i < NUM_ROB_ENTS; i++) begin
                ent_valid_r[i] <= 1'b0;
                ent_done_r[i]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (alloc_s[k]) begin
                    ent_valid_r[disp_rob_index[k*IW +: IW]] <= 1'b1;
                    ent_done_r[disp_rob_index[k*IW +: IW]]  <= 1'b0;
                    ent_exc_r[disp_rob_index[k*IW +: IW]]   <= 1'b0;
                    ent_mis_r[disp_rob_index[k*IW +: IW]]   <= 1'b0;
                    ent_areg_r[disp_rob_index[k*IW +: IW]]  <= disp_dst_areg[k*AW +: AW];
                    ent_preg_r[disp_rob_index[k*IW +: IW]]  <= disp_dst_preg[k*PW +: PW];
                    ent_old_r[disp_rob_index[k*IW +: IW]]   <= disp_old_preg[k*PW +: PW];
                    ent_pc_r[disp_rob_index[k*IW +: IW]]    <= disp_pc[k*32 +: 32];
                end
            end
            // Later ports overwrite earlier ones when indices collide.
            for (int f = 0; f < NUM_FUS; f++) begin
                if (cmpl_hit_s[f]) begin
                    ent_done_r[cmpl_rob_index[f*IW +: IW]] <= 1'b1;
                    ent_exc_r[cmpl_rob_index[f*IW +: IW]]  <= cmpl_exception[f];
                    ent_mis_r[cmpl_rob_index[f*IW +: IW]]  <= cmpl_br_mispred[f];
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (ret_valid_s[k]) begin
                    ent_valid_r[ret_idx_s[k]] <= 1'b0;
                    ent_done_r[ret_idx_s[k]]  <= 1'b0;
                end
            end
            head_r <= head_r + n_commit_s;
            tail_r <= tail_r + n_alloc_s;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed dispatch/complete stimulus pushes
// expected retire and flush records; a negedge monitor pops and compares them.
module tb_reorder_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   disp_valid;
    logic [9:0]   disp_dst_areg;
    logic [13:0]  disp_dst_preg;
    logic [13:0]  disp_old_preg;
    logic [63:0]  disp_pc;
    logic         disp_ready;
    logic [11:0]  disp_rob_index;
    logic [3:0]   cmpl_valid;
    logic [23:0]  cmpl_rob_index;
    logic [3:0]   cmpl_exception;
    logic [3:0]   cmpl_br_mispred;
    logic [3:0]   ret_valid;
    logic [19:0]  ret_dst_areg;
    logic [27:0]  ret_dst_preg;
    logic [27:0]  ret_old_preg;
    logic [127:0] ret_pc;
    logic         flush;
    logic         flush_exception;
    logic [31:0]  flush_pc;
    logic [6:0]   count;
    logic         empty;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  areg;
        logic [6:0]  preg;
        logic [6:0]  old;
    } ret_t;

    typedef struct {
        logic        exc;
        logic [31:0] pc;
    } fl_t;

    ret_t exp_q[$];
    fl_t  fl_q[$];
    ret_t mon_r;
    fl_t  mon_f;
    int   checks   = 0;
    int   failures = 0;
    int   seq      = 0;
    int   tb_tail  = 0;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .disp_valid      (disp_valid),
        .disp_dst_areg   (disp_dst_areg),
        .disp_dst_preg   (disp_dst_preg),
        .disp_old_preg   (disp_old_preg),
        .disp_pc         (disp_pc),
        .disp_ready      (disp_ready),
        .disp_rob_index  (disp_rob_index),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_index  (cmpl_rob_index),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .ret_valid       (ret_valid),
        .ret_dst_areg    (ret_dst_areg),
        .ret_dst_preg    (ret_dst_preg),
        .ret_old_preg    (ret_old_preg),
        .ret_pc          (ret_pc),
        .flush           (flush),
        .flush_exception (flush_exception),
        .flush_pc        (flush_pc),
        .count           (count),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_pc(input int s);
        return 32'h0000_1000 + 32'(s) * 32'd4;
    endfunction
    function automatic logic [4:0] f_areg(input int s);
        return 5'(s % 32);
    endfunction
    function automatic logic [6:0] f_preg(input int s);
        return 7'((s * 3 + 1) % 128);
    endfunction
    function automatic logic [6:0] f_old(input int s);
        return 7'((s * 5 + 7) % 128);
    endfunction

    function automatic logic [23:0] ix4(input int a, input int b, input int c, input int d);
        logic [5:0] ia, ib, ic, id;
        ia = 6'(a % 64);
        ib = 6'(b % 64);
        ic = 6'(c % 64);
        id = 6'(d % 64);
        return {id, ic, ib, ia};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // One cycle of stimulus; push_n of the allocated entries are expected to commit.
    task automatic step(input logic [1:0] dv, input bit alloc_ok, input int push_n,
                        input logic [3:0] cv, input logic [23:0] cidx,
                        input logic [3:0] cexc, input logic [3:0] cmis);
        int   nal;
        ret_t r;
        disp_valid = dv;
        for (int k = 0; k < 2; k++) begin
            disp_dst_areg[k*5 +: 5]  = f_areg(seq + k);
            disp_dst_preg[k*7 +: 7]  = f_preg(seq + k);
            disp_old_preg[k*7 +: 7]  = f_old(seq + k);
            disp_pc[k*32 +: 32]      = f_pc(seq + k);
        end
        cmpl_valid      = cv;
        cmpl_rob_index  = cidx;
        cmpl_exception  = cexc;
        cmpl_br_mispred = cmis;
        nal = 0;
        if (alloc_ok) begin
            nal = dv[0] ? (dv[1] ? 2 : 1) : 0;
            for (int k = 0; k < nal; k++)
                check("disp_rob_index", 32'(disp_rob_index[k*6 +: 6]), 32'((tb_tail + k) % 64));
        end
        @(posedge clk);
        #1;
        disp_valid      = 2'b00;
        cmpl_valid      = 4'b0000;
        cmpl_exception  = 4'b0000;
        cmpl_br_mispred = 4'b0000;
        for (int k = 0; k < nal; k++) begin
            if (k < push_n) begin
                r.pc   = f_pc(seq);
                r.areg = f_areg(seq);
                r.preg = f_preg(seq);
                r.old  = f_old(seq);
                exp_q.push_back(r);
            end
            seq++;
            tb_tail++;
        end
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!empty && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    task automatic fill_and_drain(input string tag);
        int base;
        base = tb_tail;
        for (int i = 0; i < 32; i++) step(2'b11, 1'b1, 2, 4'h0, 24'h0, 4'h0, 4'h0);
        @(negedge clk);
        check({tag, "_full_count"}, 32'(count), 32'd64);
        check({tag, "_full_ready"}, 32'(disp_ready), 32'd0);
        check({tag, "_full_empty"}, 32'(empty), 32'd0);
        @(posedge clk);
        #1;
        step(2'b11, 1'b0, 0, 4'h0, 24'h0, 4'h0, 4'h0);
        check({tag, "_full_ignored"}, 32'(count), 32'd64);
        for (int c = 0; c < 16; c++)
            step(2'b00, 1'b0, 0, 4'hF, ix4(base + 4*c, base + 4*c + 1, base + 4*c + 2, base + 4*c + 3),
                 4'h0, 4'h0);
        wait_empty(tag);
    endtask

    // Scoreboard monitor: every presented retire slot and flush pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (ret_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ret_unexpected slot=%0d got_pc=%0h want=none", k, ret_pc[k*32 +: 32]);
                    end else begin
                        mon_r = exp_q.pop_front();
                        check("ret_pc", ret_pc[k*32 +: 32], mon_r.pc);
                        check("ret_dst_areg", 32'(ret_dst_areg[k*5 +: 5]), 32'(mon_r.areg));
                        check("ret_dst_preg", 32'(ret_dst_preg[k*7 +: 7]), 32'(mon_r.preg));
                        check("ret_old_preg", 32'(ret_old_preg[k*7 +: 7]), 32'(mon_r.old));
                    end
                end
            end
            if (ret_valid != 4'b0000)
                check("ret_prefix", 32'((5'(ret_valid) + 5'd1) & 5'(ret_valid)), 32'd0);
            if (flush) begin
                if (fl_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL flush_unexpected got_pc=%0h want=none", flush_pc);
                end else begin
                    mon_f = fl_q.pop_front();
                    check("flush_exception", 32'(flush_exception), 32'(mon_f.exc));
                    check("flush_pc", flush_pc, mon_f.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int s0;
        fl_t f;
        disp_valid      = 2'b00;
        disp_dst_areg   = '0;
        disp_dst_preg   = '0;
        disp_old_preg   = '0;
        disp_pc         = '0;
        cmpl_valid      = 4'h0;
        cmpl_rob_index  = '0;
        cmpl_exception  = 4'h0;
        cmpl_br_mispred = 4'h0;
        rst = 1'b1;
        #3;
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_flush_exc", 32'(flush_exception), 32'd0);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        fill_and_drain("fill0");

        // Reverse-order completion: nothing retires until the oldest is done.
        b = tb_tail;
        for (int i = 0; i < 4; i++) step(2'b11, 1'b1, 2, 4'h0, 24'h0, 4'h0, 4'h0);
        for (int j = 7; j >= 1; j--) begin
            step(2'b00, 1'b0, 0, 4'b0001, ix4(b + j, 0, 0, 0), 4'h0, 4'h0);
            check("rev_no_retire", 32'(ret_valid), 32'd0);
        end
        step(2'b00, 1'b0, 0, 4'b0001, ix4(b, 0, 0, 0), 4'h0, 4'h0);
        check("rev_ret_first", 32'(ret_valid), 32'hF);
        @(posedge clk);
        #1;
        check("rev_ret_second", 32'(ret_valid), 32'hF);
        @(posedge clk);
        #1;
        check("rev_empty", 32'(empty), 32'd1);

        // Mispredict on the third entry: three commit, flush to head+3.
        b  = tb_tail;
        s0 = seq;
        f.exc = 1'b0;
        f.pc  = f_pc(s0 + 2);
        fl_q.push_back(f);
        step(2'b11, 1'b1, 2, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b11, 1'b1, 1, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b11, 1'b1, 0, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b00, 1'b0, 0, 4'hF, ix4(b, b + 1, b + 2, b + 3), 4'b0000, 4'b0100);
        check("mis_ret_valid", 32'(ret_valid), 32'b0111);
        check("mis_flush", 32'(flush), 32'd1);
        check("mis_flush_exc", 32'(flush_exception), 32'd0);
        check("mis_flush_pc", flush_pc, f_pc(s0 + 2));
        @(posedge clk);
        #1;
        tb_tail = b + 3;
        check("mis_count", 32'(count), 32'd0);
        check("mis_tail", 32'(disp_rob_index[5:0]), 32'(tb_tail % 64));

        // Exception on the second entry: one commits, flush to head+2, flush-cycle dispatch dropped.
        b  = tb_tail;
        s0 = seq;
        f.exc = 1'b1;
        f.pc  = f_pc(s0 + 1);
        fl_q.push_back(f);
        step(2'b11, 1'b1, 1, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b11, 1'b1, 0, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b00, 1'b0, 0, 4'b0111, ix4(b, b + 1, b + 2, 0), 4'b0010, 4'b0000);
        check("exc_ret_valid", 32'(ret_valid), 32'b0001);
        check("exc_flush", 32'(flush), 32'd1);
        check("exc_flush_exc", 32'(flush_exception), 32'd1);
        check("exc_disp_ready", 32'(disp_ready), 32'd0);
        step(2'b11, 1'b0, 0, 4'b0001, ix4(b + 3, 0, 0, 0), 4'h0, 4'h0);
        tb_tail = b + 2;
        check("exc_count", 32'(count), 32'd0);
        check("exc_ret_after", 32'(ret_valid), 32'd0);
        check("exc_tail", 32'(disp_rob_index[5:0]), 32'(tb_tail % 64));

        // Non-contiguous request allocates nothing; single-slot request allocates one.
        step(2'b10, 1'b0, 0, 4'h0, 24'h0, 4'h0, 4'h0);
        check("gap_count", 32'(count), 32'd0);
        step(2'b01, 1'b1, 1, 4'h0, 24'h0, 4'h0, 4'h0);
        check("single_count", 32'(count), 32'd1);

        // Completion to the entry being allocated this cycle and to a far index is ignored.
        b = tb_tail;
        step(2'b01, 1'b1, 1, 4'b0111, ix4(b - 1, b, b + 26, 0), 4'h0, 4'h0);
        check("oor_ret_valid", 32'(ret_valid), 32'b0001);
        @(posedge clk);
        #1;
        check("oor_count", 32'(count), 32'd1);
        check("oor_no_retire", 32'(ret_valid), 32'd0);
        step(2'b00, 1'b0, 0, 4'b0001, ix4(b, 0, 0, 0), 4'h0, 4'h0);
        check("oor_late_ret", 32'(ret_valid), 32'b0001);
        wait_empty("oor");

        // Long streaming run so both pointers wrap several times.
        for (int c = 0; c < 200; c++) begin
            if (c == 0)
                step(2'b11, 1'b1, 2, 4'h0, 24'h0, 4'h0, 4'h0);
            else
                step(2'b11, 1'b1, 2, 4'b0011, ix4(tb_tail - 2, tb_tail - 1, 0, 0), 4'h0, 4'h0);
        end
        step(2'b00, 1'b0, 0, 4'b0011, ix4(tb_tail - 2, tb_tail - 1, 0, 0), 4'h0, 4'h0);
        wait_empty("wrap");
        check("wrap_tail", 32'(disp_rob_index[5:0]), 32'(tb_tail % 64));

        fill_and_drain("fill1");

        // Asynchronous reset while two entries are presenting retire.
        step(2'b11, 1'b1, 0, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b00, 1'b0, 0, 4'b0011, ix4(tb_tail - 2, tb_tail - 1, 0, 0), 4'h0, 4'h0);
        check("pre_rst_ret", 32'(ret_valid), 32'b0011);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ret_valid", 32'(ret_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ready", 32'(disp_ready), 32'd1);
        check("mid_rst_flush", 32'(flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tb_tail = 0;
        step(2'b01, 1'b1, 1, 4'h0, 24'h0, 4'h0, 4'h0);
        step(2'b00, 1'b0, 0, 4'b0001, ix4(0, 0, 0, 0), 4'h0, 4'h0);
        wait_empty("post_rst");

        @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("fl_q_drained", 32'(fl_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between dispatch and retire in the out-of-order core. Allocates up to DISP_WIDTH entries per cycle in program order. Records completion status from the NUM_FUS execution pipes (ALU_LOWER, ALU_UPPER, MUL, LSU). Retires up to RETIRE_WIDTH oldest completed entries per cycle, returning old physical registers to the free list and raising a flush on a mispredict or exception.

## Interface
- NUM_ROB_ENTS, 64: entries; power of two.
- DISP_WIDTH, 2: allocate slots per cycle.
- RETIRE_WIDTH, 4: retire slots per cycle.
- NUM_FUS, 4: completion ports, one per execution pipe.
- NUM_AREGS, 32 / NUM_PREGS, 128: architectural / physical register counts.
- Widths: IW = clog2(NUM_ROB_ENTS), AW = clog2(NUM_AREGS), PW = clog2(NUM_PREGS).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  DISP_WIDTH  per-slot allocate request; slot 0 is oldest.
- disp_dst_areg  in  DISP_WIDTH*AW  destination architectural register.
- disp_dst_preg / disp_old_preg  in  DISP_WIDTH*PW  new and previous mapping.
- disp_pc  in  DISP_WIDTH*32  instruction PC.
- disp_ready  out  1  ROB can accept DISP_WIDTH entries this cycle.
- disp_rob_index  out  DISP_WIDTH*IW  index given to each slot: tail+k.
- cmpl_valid  in  NUM_FUS  completion strobe.
- cmpl_rob_index  in  NUM_FUS*IW  completing entry.
- cmpl_exception / cmpl_br_mispred  in  NUM_FUS  completion flags.
- ret_valid  out  RETIRE_WIDTH  entry k commits; always a contiguous prefix.
- ret_dst_areg / ret_dst_preg / ret_old_preg / ret_pc  out  per slot  committed entry fields; ret_old_preg goes to the free list.
- flush  out  1  pipeline flush.
- flush_exception  out  1  flush cause is an exception; 0 means mispredict.
- flush_pc  out  32  PC of the offending entry.
- count  out  IW+1  occupied entries.
- empty  out  1  count == 0.

## Operation
- **Pointers.** head and tail are IW+1 bits; the extra bit is the wrap bit. Entry index is ptr[IW-1:0]. count = tail − head, modulo 2^(IW+1). Full when count == NUM_ROB_ENTS.
- **Entry state.** Each entry holds valid, done, exception, br_mispred, areg, preg, old_preg, pc.
- **Dispatch.**
  - disp_ready = (NUM_ROB_ENTS − count ≥ DISP_WIDTH) && !flush. count is the value at the start of the cycle; same-cycle retires do not add space.
  - Allocate only the leading contiguous run of set disp_valid bits (2'b10 allocates nothing).
  - Allocated entries get valid=1, done=0. tail advances by the number allocated.
  - disp_valid while disp_ready=0 is ignored.
- **Completion.**
  - An entry is in range if its index lies in [head, tail) at the start of the cycle. Out-of-range completions are ignored.
  - An in-range completion sets done, exception and br_mispred.
  - Several ports may complete distinct entries in one cycle. The same index on two ports is an upstream error; the higher-numbered port wins.
- **Retire (combinational from current state).**
  - Scan entries head+0 .. head+RETIRE_WIDTH−1.
  - Slot k is eligible if its entry is valid and done, and every earlier slot is eligible and not flagged.
  - Eligible entry with br_mispred: ret_valid=1 for that slot, flush=1, flush_exception=0, flush_pc=its pc. Scan stops there.
  - Eligible entry with exception: ret_valid=0 for that slot, flush=1, flush_exception=1, flush_pc=its pc. Scan stops; the entry does not commit.
  - head advances by the number of committed entries.
- **Flush edge.**
  - All entries are cleared: valid=0, done=0.
  - head = tail = (head + committed + 1 if exception, else head + committed).
  - Dispatch and completions arriving in the flush cycle are discarded.
- **Reset.** head=tail=0, all valid/done cleared. Outputs: disp_ready=1, ret_valid=0, flush=0, flush_exception=0, flush_pc=0, count=0, empty=1.

## Timing
- Allocation takes effect at the clock edge ending the dispatch cycle. disp_rob_index is valid combinationally in the dispatch cycle.
- Completion at edge N makes the entry retire-eligible in cycle N+1. There is no same-cycle completion-to-retire bypass.
- Retire outputs and flush are combinational from registered state. Pointer and valid updates happen at the following edge.
- Minimum dispatch-to-retire: 2 cycles (allocate edge, completion edge, retire in the next cycle).
- Wrap-around: indices wrap modulo NUM_ROB_ENTS. The full/empty distinction uses the wrap bit.
- Asynchronous rst mid-operation clears all state immediately. Outputs take their reset values while rst is high.

## Test plan
- Reset, then dispatch 2/cycle for 32 cycles with no completions -> count=64, disp_ready=0 once count reaches 63; indices 0..63 assigned in order.
- Fill 8 entries, complete in reverse order -> no retire until index 0 completes. Then ret_valid=4'b1111 for indices 0-3, next cycle indices 4-7; ret_pc follows program order.
- Complete entry 2 with br_mispred among done entries 0-3 -> ret_valid=4'b0111, flush=1, flush_pc=pc of entry 2. Next cycle count=0, head=tail=3.
- Complete entry 1 with exception -> ret_valid=4'b0001, flush=1, flush_exception=1. Next cycle head=tail=2; dispatch in the flush cycle dropped.
- Run 200 dispatch/retire cycles with wrap -> head wraps past 63 to 0 with wrap bit toggled; empty and full are correct at both boundaries.
- Completion to an index not in [head, tail) -> ignored; rst asserted mid-stream -> all outputs return to reset values without a clock edge.
